// File: rtl/bram_port_b_ctrl.sv
// bram_port_b_ctrl: single-outstanding request controller for port B of the
// local BRAM block. Converts a valid/ready request/response interface into
// BRAM enable / write-enable / address / data cycles. Read data is captured
// one cycle after issue.
//
// Optional feature macro: BRAM_CTRL_CLEAR_EN -- when defined, a Clr_Start
// pulse walks every word of the window and writes zero to it.
//
// Handshake: a request transfers on any rising Clk edge where Req_Valid and
// Req_Ready are both high; a response transfers on any edge where Rsp_Valid
// and Rsp_Ready are both high. Once Rsp_Valid rises, Rsp_Valid, Rsp_Err and
// Rsp_RData hold steady until that transfer.
//
// Vectors are big-endian ([0:N-1], bit 0 is the MSB, byte lane 0 is [0:7]).
module bram_port_b_ctrl #(
  parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
  parameter logic [31:0] C_MEMSIZE     = 32'h0000_4000,
  parameter int          C_PORT_AWIDTH = 32,
  parameter int          C_PORT_DWIDTH = 32,
  parameter int          C_NUM_WE      = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Req_Valid,
  output logic                     Req_Ready,
  input  logic                     Req_Wr,
  input  logic [0:C_NUM_WE-1]      Req_BE,
  input  logic [0:31]              Req_Addr,
  input  logic [0:C_PORT_DWIDTH-1] Req_WData,
  output logic                     Rsp_Valid,
  input  logic                     Rsp_Ready,
  output logic                     Rsp_Err,
  output logic [0:C_PORT_DWIDTH-1] Rsp_RData,
  output logic                     BRAM_Rst,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din,
  input  logic                     Clr_Start,
  output logic                     Clr_Busy,
  output logic                     Clr_Done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_RESP    = 3'd3
`ifdef BRAM_CTRL_CLEAR_EN
    , S_CLEAR = 3'd4
`endif
  } state_e;

  state_e                     state_q, state_d;
  logic                       wr_q, wr_d;
  logic [0:C_NUM_WE-1]        be_q, be_d;
  logic [0:31]                addr_q, addr_d;
  logic [0:C_PORT_DWIDTH-1]   wdata_q, wdata_d;
  logic                       err_q, err_d;
  logic [0:C_PORT_DWIDTH-1]   rdata_q, rdata_d;

  logic                       bram_en_c;
  logic [0:C_NUM_WE-1]        bram_wen_c;
  logic [0:C_PORT_AWIDTH-1]   bram_addr_c;
  logic [0:C_PORT_DWIDTH-1]   bram_dout_c;

  // Window decode on the captured address; subtraction wraps at 32 bits so
  // addresses below the base land far above C_MEMSIZE and fail the test.
  logic [31:0] offset;
  logic        in_window;
  logic [31:0] word_addr;

  assign offset    = addr_q - C_BASEADDR;
  assign in_window = (offset < C_MEMSIZE);
  assign word_addr = offset & (C_MEMSIZE - 32'd1) & ~32'h3;

`ifdef BRAM_CTRL_CLEAR_EN
  localparam int          CNT_W    = $clog2(C_MEMSIZE / 4);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((C_MEMSIZE / 4) - 1);

  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_pend_q, clr_pend_d;
  logic             clr_done_q, clr_done_d;
  logic             clr_go;

  // A clear is launched from IDLE by a fresh pulse or a deferred one.
  assign clr_go    = Clr_Start | clr_pend_q;
  assign Req_Ready = (state_q == S_IDLE) & ~Clr_Start & ~clr_pend_q;
  assign Clr_Busy  = (state_q == S_CLEAR);
  assign Clr_Done  = clr_done_q;
`else
  logic clr_start_unused;

  assign clr_start_unused = Clr_Start;
  assign Req_Ready = (state_q == S_IDLE);
  assign Clr_Busy  = 1'b0;
  assign Clr_Done  = 1'b0;
`endif

  assign Rsp_Valid = (state_q == S_RESP);
  assign Rsp_Err   = err_q;
  assign Rsp_RData = rdata_q;
  assign BRAM_Rst  = ~Rst_n;
  assign BRAM_EN   = bram_en_c;
  assign BRAM_WEN  = bram_wen_c;
  assign BRAM_Addr = bram_addr_c;
  assign BRAM_Dout = bram_dout_c;

  // State and datapath registers; async reset returns everything to idle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef BRAM_CTRL_CLEAR_EN
  // Clear engine registers: word counter, deferred-start flag, done pulse.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      clr_cnt_q  <= '0;
      clr_pend_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      clr_cnt_q  <= clr_cnt_d;
      clr_pend_q <= clr_pend_d;
      clr_done_q <= clr_done_d;
    end
  end
`endif

  // Next-state logic and BRAM port drive; BRAM outputs are idle-zero by default.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    bram_en_c   = 1'b0;
    bram_wen_c  = '0;
    bram_addr_c = '0;
    bram_dout_c = '0;
`ifdef BRAM_CTRL_CLEAR_EN
    clr_cnt_d   = '0;
    clr_pend_d  = clr_pend_q;
    clr_done_d  = 1'b0;
    // A pulse arriving mid-transaction is remembered; one arriving while
    // already clearing is dropped.
    if (Clr_Start && (state_q != S_IDLE) && (state_q != S_CLEAR)) begin
      clr_pend_d = 1'b1;
    end
`endif

    case (state_q)
      S_IDLE: begin
`ifdef BRAM_CTRL_CLEAR_EN
        if (clr_go) begin
          clr_pend_d = 1'b0;
          state_d    = S_CLEAR;
        end else
`endif
        if (Req_Valid) begin
          wr_d    = Req_Wr;
          be_d    = Req_BE;
          addr_d  = Req_Addr;
          wdata_d = Req_WData;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        rdata_d = '0;
        if (in_window) begin
          bram_en_c   = 1'b1;
          bram_wen_c  = wr_q ? be_q : '0;
          bram_addr_c = C_PORT_AWIDTH'(word_addr);
          bram_dout_c = wdata_q;
          err_d       = 1'b0;
          state_d     = wr_q ? S_RESP : S_CAPTURE;
        end else begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end

      S_CAPTURE: begin
        rdata_d = BRAM_Din;
        state_d = S_RESP;
      end

      S_RESP: begin
        if (Rsp_Ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

`ifdef BRAM_CTRL_CLEAR_EN
      S_CLEAR: begin
        bram_en_c   = 1'b1;
        bram_wen_c  = '1;
        bram_addr_c = C_PORT_AWIDTH'({clr_cnt_q, 2'b00});
        bram_dout_c = '0;
        if (clr_cnt_q == CNT_LAST) begin
          clr_done_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
